uart_telemetry_sched: RTL
=========================

Name: uart_telemetry_sched

Overview:
Periodic telemetry scheduler that sequences the byte-level UART transmitter. It snapshots NUM_CH 16-bit status words from the motor/PID datapath and frames them into a packet. It feeds the packet one byte at a time through the transmitter's data/data_valid/busy handshake. Sits between the PID core status outputs and the UART TX instance; the sole driver of the transmitter's data inputs.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz (documentation/derivation only)
PERIOD_CLKS, 1_000_000, clocks between periodic packet triggers (min 2)
NUM_CH, 4, number of 16-bit channels per packet (1..8)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  periodic scheduling enable
trig  in  1  single-cycle manual packet request
ch_data  in  NUM_CH*16  channel words; ch k = ch_data[16k+15:16k]
tx_data  out  8  byte to transmitter
tx_valid  out  1  one-cycle byte strobe to transmitter
tx_busy  in  1  transmitter busy
pkt_active  out  1  high from snapshot until last byte's busy falls
seq  out  8  sequence number of next packet
overrun_cnt  out  8  saturating count of dropped triggers

Behaviour:
- Reset is asynchronous, active-low, on one clock (clk, rst_n). All outputs reset to 0, the period counter resets to 0, and the FSM resets to IDLE.
- Period counter:
  - While enable=1, counts 0..PERIOD_CLKS-1 and wraps.
  - tick = counter at PERIOD_CLKS-1.
  - enable=0 holds the counter at 0.
- Request = tick OR trig. Simultaneous tick and trig counts as one request.
- Packet bytes, in order: 0xAA, 0x55, seq, then for k=0..NUM_CH-1: ch k [15:8], ch k [7:0]; then CHK.
  - Total length is 2*NUM_CH+4 bytes.
  - CHK = 8-bit modulo-256 sum of seq and all data bytes; the header is excluded.
- FSM states: IDLE, SNAP, SEND, WAIT_HI, WAIT_LO.
  - IDLE: on request, go to SNAP.
  - SNAP: latch ch_data into the snapshot register, clear byte index and checksum, set pkt_active=1.
    - Latency from request to snapshot: 1 cycle.
    - ch_data changes after SNAP do not affect the packet.
  - SEND: only if tx_busy=0, drive tx_data = current byte and tx_valid=1 for exactly one cycle, then go to WAIT_HI. If tx_busy=1, stay in SEND with tx_valid=0.
  - WAIT_HI: wait until tx_busy=1. The transmitter raises busy the cycle after the strobe.
  - WAIT_LO: wait until tx_busy=0.
    - If more bytes remain: increment the index and return to SEND.
    - After the final byte: clear pkt_active, increment seq (wraps 0xFF->0x00), go to IDLE.
- Checksum accumulates each data/seq byte as it is strobed. CHK is therefore available when its slot is reached; no extra cycle.
- Request while pkt_active=1 or in SNAP:
  - The request is dropped and no queueing occurs.
  - overrun_cnt increments, saturating at 0xFF.
- tx_valid is never asserted while tx_busy=1.
- tx_data holds its value between strobes.
- Reset mid-packet: FSM returns to IDLE immediately and seq returns to 0. A byte already accepted by the transmitter completes there; no further strobes are issued.

Optional Feature:
TELEM_CRC8_EN
- Defined: CHK is CRC-8 (poly 0x07, init 0x00, no reflection, no final XOR) over seq and the data bytes. It is computed one byte per strobe using a combinational 8-step bitwise update.
- Undefined: CHK is the modulo-256 additive checksum.
- Packet length and timing are identical in both builds.

Decomposition:
- Package telem_pkg:
  - header constants HDR0=8'hAA, HDR1=8'h55
  - CRC8_POLY=8'h07
  - FSM state encoding localparams
  - function pkt_len(NUM_CH) = 2*NUM_CH+4
- One natural sub-module, telem_chk_unit: checksum/CRC-8 accumulator with clear, byte_in and update_en inputs, and chk output. Its CRC path is selected by TELEM_CRC8_EN.

Test Plan:
- Bench: NUM_CH=2, PERIOD_CLKS=50, with uart_tx model (busy rises 1 cycle after valid, held 20 cycles).
- trig with ch_data=32'hABCD_1234, seq=0 -> bytes AA 55 00 12 34 AB CD BE; seq becomes 1; pkt_active drops after the final busy falls.
- Same stimulus with TELEM_CRC8_EN -> final byte equals CRC-8/0x07 of {00,12,34,AB,CD}, checked against the bench reference model; the first 7 bytes are unchanged.
- enable=1 with packet time > PERIOD_CLKS -> overrun_cnt increments once per dropped tick; packets remain contiguous; no tx_valid while tx_busy=1.
- ch_data changed 1 cycle after SNAP -> transmitted bytes match the pre-change value.
- rst_n asserted during the 4th byte -> tx_valid=0, pkt_active=0, seq=0 immediately; a fresh trig then produces a full packet with seq=00.
- 256 consecutive packets -> seq wraps FF->00; 300 forced overruns -> overrun_cnt saturates at FF.

Source files
------------

// File: rtl/uart_telemetry_sched_pkg.sv
// Shared constants, state encoding and packet-length helper for the telemetry scheduler.
package telem_pkg;

    localparam logic [7:0] HDR0      = 8'hAA;
    localparam logic [7:0] HDR1      = 8'h55;
    localparam logic [7:0] CRC8_POLY = 8'h07;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SNAP    = 3'd1;
    localparam logic [2:0] ST_SEND    = 3'd2;
    localparam logic [2:0] ST_WAIT_HI = 3'd3;
    localparam logic [2:0] ST_WAIT_LO = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        SNAP    = ST_SNAP,
        SEND    = ST_SEND,
        WAIT_HI = ST_WAIT_HI,
        WAIT_LO = ST_WAIT_LO
    } state_t;

    // Byte index width; covers the longest packet (NUM_CH=8 -> 20 bytes).
    localparam int unsigned IDX_W = 5;

    function automatic int unsigned pkt_len(input int unsigned num_ch);
        return 2 * num_ch + 4;
    endfunction

endpackage

// File: rtl/uart_telemetry_sched_chk_unit.sv
// Packet check-byte accumulator: modulo-256 sum by default, CRC-8 (poly 0x07) when
// TELEM_CRC8_EN is defined.
module telem_chk_unit
    import telem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       update_en,
    input  logic [7:0] byte_in,
    output logic [7:0] chk
);

    logic [7:0] chk_next_c;

`ifdef TELEM_CRC8_EN
    // MSB-first CRC-8, one full byte folded in per update.
    always_comb begin
        chk_next_c = chk ^ byte_in;
        for (int i = 0; i < 8; i++) begin
            if (chk_next_c[7])
                chk_next_c = {chk_next_c[6:0], 1'b0} ^ CRC8_POLY;
            else
                chk_next_c = {chk_next_c[6:0], 1'b0};
        end
    end
`else
    always_comb begin
        chk_next_c = chk + byte_in;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            chk <= 8'h00;
        else if (clear)
            chk <= 8'h00;
        else if (update_en)
            chk <= chk_next_c;
    end

endmodule

// File: rtl/uart_telemetry_sched.sv
// Periodic telemetry packet scheduler feeding a byte UART transmitter.
// Define TELEM_CRC8_EN to make the trailing check byte a CRC-8 instead of a sum.
module uart_telemetry_sched
    import telem_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 100_000_000,
    parameter int unsigned PERIOD_CLKS = 1_000_000,
    parameter int unsigned NUM_CH      = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   trig,
    input  logic [NUM_CH*16-1:0]   ch_data,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_busy,
    output logic                   pkt_active,
    output logic [7:0]             seq,
    output logic [7:0]             overrun_cnt
);

    localparam int unsigned CNT_W   = $clog2(PERIOD_CLKS);
    localparam int unsigned PKT_LEN = pkt_len(NUM_CH);
    localparam int unsigned DW      = NUM_CH * 16;

    if (CLK_FREQ == 0) begin : g_bad_clk
        $error("CLK_FREQ must be non-zero");
    end
    if (PERIOD_CLKS < 2) begin : g_bad_period
        $error("PERIOD_CLKS must be at least 2");
    end
    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_ch
        $error("NUM_CH must be in 1..8");
    end

    logic [CNT_W-1:0] cnt;
    logic             tick_c;
    logic             req_c;
    state_t           state;
    logic [DW-1:0]    snap;
    logic [IDX_W-1:0] idx;
    logic [7:0]       cur_byte_c;
    logic [7:0]       chk;
    logic             chk_clr_c;
    logic             chk_upd_c;
    logic             last_c;

    assign tick_c = enable && (cnt == CNT_W'(PERIOD_CLKS - 1));
    assign req_c  = tick_c || trig;

    // Free-running period counter, parked at zero while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (!enable || tick_c)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

    // Byte mux: header, seq, snapshot bytes (high byte first per channel), check byte.
    always_comb begin
        cur_byte_c = chk;
        if (idx == IDX_W'(0))
            cur_byte_c = HDR0;
        else if (idx == IDX_W'(1))
            cur_byte_c = HDR1;
        else if (idx == IDX_W'(2))
            cur_byte_c = seq;
        else begin
            for (int unsigned b = 0; b < 2 * NUM_CH; b++) begin
                if (idx == IDX_W'(b + 3))
                    cur_byte_c = snap[8 * (b ^ 32'd1) +: 8];
            end
        end
    end

    assign last_c    = (idx == IDX_W'(PKT_LEN - 1));
    assign chk_clr_c = (state == SNAP);
    assign chk_upd_c = (state == SEND) && !tx_busy &&
                       (idx >= IDX_W'(2)) && (idx < IDX_W'(PKT_LEN - 1));

    telem_chk_unit u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (chk_clr_c),
        .update_en (chk_upd_c),
        .byte_in   (cur_byte_c),
        .chk       (chk)
    );

    // Packet sequencer; any request outside IDLE is dropped and counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            snap        <= '0;
            idx         <= '0;
            tx_data     <= 8'h00;
            tx_valid    <= 1'b0;
            pkt_active  <= 1'b0;
            seq         <= 8'h00;
            overrun_cnt <= 8'h00;
        end else begin
            tx_valid <= 1'b0;
            if (req_c && (state != IDLE) && (overrun_cnt != 8'hFF))
                overrun_cnt <= overrun_cnt + 8'd1;

            case (state)
                IDLE: begin
                    if (req_c)
                        state <= SNAP;
                end
                SNAP: begin
                    snap       <= ch_data;
                    idx        <= '0;
                    pkt_active <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    if (!tx_busy) begin
                        tx_data  <= cur_byte_c;
                        tx_valid <= 1'b1;
                        state    <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (tx_busy)
                        state <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        if (last_c) begin
                            pkt_active <= 1'b0;
                            seq        <= seq + 8'd1;
                            state      <= IDLE;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
